ahb_sram_pattern_master: RTL
============================

# ahb_sram_pattern_master

Parametrised, synthesisable AHB-lite master that exercises the SRAM controller (`sramc_top`) without a software testbench. On `start` it writes `NUM_WORDS` words of a selectable data pattern from `BASE_ADDR`, reads them back, and checks each read word. It reports pass/fail, an error count and the first failing address. It replaces the fixed-function SV test harness as the bring-up and regression driver, in both simulation and FPGA builds.

## Interface
Parameters:
- `ADDR_W`, 32, width of `haddr`.
- `DATA_W`, 32, data width: 8, 16 or 32. Transfer size is fixed at `hsize = log2(DATA_W/8)`.
- `NUM_WORDS`, 256, words per run, ≥1.
- `BASE_ADDR`, 0, first byte address, aligned to `DATA_W/8`.
- `SEED`, 32'h0000_0001, LFSR seed, non-zero.
- `ERR_W`, 16, width of `err_cnt`.

Ports:
- `hclk` in 1: single clock.
- `hresetn` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle run request.
- `mode` in 2: pattern select, sampled on accepted `start`.
- `hsel` out 1: slave select.
- `hwrite` out 1: 1 = write.
- `htrans` out 2: IDLE=00 or NONSEQ=10 only.
- `hsize` out 3: constant, see `DATA_W`.
- `hburst` out 3: constant 3'b000.
- `haddr` out `ADDR_W`: address.
- `hwdata` out `DATA_W`: write data.
- `hready` out 1: bus ready to slave; equals `hready_resp`.
- `hready_resp` in 1: slave ready.
- `hresp` in 2: 00 OKAY, 01 ERROR.
- `hrdata` in `DATA_W`: read data.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until next accepted `start`.
- `pass` out 1: `done` and `err_cnt == 0`.
- `err_cnt` out `ERR_W`: mismatches plus ERROR responses, saturating.
- `first_err_addr` out `ADDR_W`: address of the first error in the run.

## Operation
- FSM states: IDLE, WRITE, TURN, READ, RD_LAST, DONE.
- IDLE/DONE:
  - `start` = 1 clears `err_cnt`, `first_err_addr`, `done`, `pass`.
  - Latches `mode`, loads the LFSR with `SEED`, zeroes the word index, sets `busy`, and goes to WRITE.
  - `start` is ignored in all other states.
- WRITE:
  - Drives `hsel`=1, `htrans`=NONSEQ, `hwrite`=1, `haddr = BASE_ADDR + i*(DATA_W/8)`.
  - `i` advances when `hready_resp` = 1.
  - `hwdata` for word i is driven in the cycle after its address phase is accepted.
  - After word `NUM_WORDS-1` is accepted, goes to TURN.
- TURN:
  - `htrans`=IDLE, `hsel`=0 while the last write data phase completes.
  - Waits for `hready_resp` = 1, reloads the LFSR with `SEED`, zeroes `i`, goes to READ.
- READ: same address sequence as WRITE with `hwrite`=0. After the last address phase is accepted, goes to RD_LAST with `htrans`=IDLE.
- RD_LAST: when the final data phase is accepted (`hready_resp` = 1), goes to DONE. `busy`=0, `done`=1, `pass` updated.
- Patterns (`DATA_W` bits, word i):
  - 00: i, incrementing.
  - 01: LFSR. 32-bit Galois, taps 0x80200003, shifted once per word, low `DATA_W` bits used.
  - 10: alternating, all-ones for even i and all-zeros for odd i.
  - 11: address-as-data, the low `DATA_W` bits of `haddr`.
- Expected read data for word i equals the data written for word i. The read-side generator is regenerated, not stored.
- Checking happens in each read data phase with `hready_resp` = 1:
  - `hrdata` ≠ expected → error.
  - `hresp` = ERROR in any data phase, read or write → error.
  - Each error increments `err_cnt`, saturating at all-ones. The first error in a run records the address of that data phase in `first_err_addr`.
  - A transfer with both a mismatch and ERROR counts once.

## Timing
- Reset values:
  - `hsel` 0, `hwrite` 0, `htrans` 00, `haddr` 0, `hwdata` 0.
  - `busy` 0, `done` 0, `pass` 0, `err_cnt` 0, `first_err_addr` 0.
  - FSM in IDLE.
- Constant outputs: `hready` = `hready_resp`; `hsize` and `hburst` are constant.
- Accepted `start` at edge N → first NONSEQ at edge N+1.
- Zero-wait slave:
  - Writes span `NUM_WORDS` address cycles, then 1 TURN cycle.
  - Reads span `NUM_WORDS` address cycles, then 1 RD_LAST cycle.
  - `done` rises at edge N + 2·`NUM_WORDS` + 3.
- Wait states: `hready_resp` = 0 stalls all phases. `haddr`, `htrans`, `hwrite` and `hwdata` hold stable, and no check occurs.
- `hresetn` low mid-run: outputs return to reset values immediately (asynchronous), and the bus is IDLE. No partial status is kept.
- `NUM_WORDS` = 1: each phase is a single NONSEQ; the FSM still passes through TURN and RD_LAST.
- All outputs are registered except `hready`.

## Test plan
- Reset then `start`, `mode`=00, `NUM_WORDS`=16, zero-wait `sramc_top` → `done` at start+35 cycles, `pass`=1, `err_cnt`=0; read data 0..15.
- `mode`=01, `SEED`=1 → first written word 0x00000001. Read-back matches, `pass`=1.
- Slave model flips bit 0 of word 5, `mode`=11, `BASE_ADDR`=0 → `err_cnt`=1, `first_err_addr`=0x14, `pass`=0.
- Random `hready_resp` low bursts of 1–3 cycles → address/data held stable while stalled (assertion), `pass`=1, `done` delayed by the total stall count.
- `hresp`=ERROR on write 2 and read 7 → `err_cnt`=2, `first_err_addr`=0x08.
- `hresetn` pulsed low during READ → all outputs at reset values within the same cycle. A new `start` then completes with `pass`=1. A `start` pulse during a run is ignored.

Source files
------------

// File: rtl/ahb_sram_pattern_master_if.sv
// AHB-lite bus bundle between the pattern master and the SRAM controller.
interface ahb_sram_pattern_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hready_resp;
  logic [1:0]        hresp;
  logic [DATA_W-1:0] hrdata;

  modport master (
    output hsel, hwrite, htrans, hsize, hburst, haddr, hwdata, hready,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  hsel, hwrite, htrans, hsize, hburst, haddr, hwdata, hready,
    output hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_pattern_master.sv
// Self-contained AHB-lite pattern master: writes NUM_WORDS words of a
// selectable pattern, reads them back, and reports error count and the
// address of the first failing data phase.
module ahb_sram_pattern_master #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                NUM_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [31:0]       SEED      = 32'h0000_0001,
  parameter int                ERR_W     = 16
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      start,
  input  logic [1:0]                mode,
  ahb_sram_pattern_master_if.master bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_cnt,
  output logic [ADDR_W-1:0]         first_err_addr
);

  localparam int          BYTES  = DATA_W / 8;
  localparam int          IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [2:0]  HSIZE  = (DATA_W == 8) ? 3'd0 : (DATA_W == 16) ? 3'd1 : 3'd2;
  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_NSEQ = 2'b10;
  localparam logic [31:0] TAPS   = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_TURN, S_READ, S_RD_LAST, S_DONE
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (&c) ? c : c + ERR_W'(1);
  endfunction

  function automatic logic [DATA_W-1:0] gen_pattern(
    input logic [1:0]        m,
    input logic [IDX_W-1:0]  i,
    input logic [31:0]       l,
    input logic [ADDR_W-1:0] a
  );
    case (m)
      2'b00:   return DATA_W'(i);
      2'b01:   return DATA_W'(l);
      2'b10:   return i[0] ? '0 : '1;
      default: return DATA_W'(a);
    endcase
  endfunction

  state_t            state_q;
  logic              hsel_q, hwrite_q;
  logic [1:0]        htrans_q;
  logic [ADDR_W-1:0] haddr_q;
  logic [DATA_W-1:0] hwdata_q;
  logic              busy_q, done_q, pass_q;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0] first_err_q;
  logic [1:0]        mode_q;
  logic [31:0]       lfsr_q;
  logic [IDX_W-1:0]  idx_q;
  // Data-phase tracking: what the slave is currently completing.
  logic              dp_vld_q, dp_wr_q;
  logic [ADDR_W-1:0] dp_addr_q;
  logic [DATA_W-1:0] dp_exp_q;

  logic              addr_acc, chk_err, last_word;
  logic [DATA_W-1:0] cur_pat;

  // Pattern for the word in the current address phase and the error check
  // for the data phase completing this cycle.
  always_comb begin
    cur_pat   = gen_pattern(mode_q, idx_q, lfsr_q, haddr_q);
    addr_acc  = bus.hready_resp && (htrans_q == T_NSEQ);
    chk_err   = dp_vld_q && bus.hready_resp &&
                ((bus.hresp == 2'b01) || (!dp_wr_q && (bus.hrdata != dp_exp_q)));
    err_cnt_d = chk_err ? sat_inc(err_cnt_q) : err_cnt_q;
    last_word = (idx_q == IDX_W'(NUM_WORDS - 1));
  end

  // Run FSM with registered bus and status outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= S_IDLE;
      hsel_q      <= 1'b0;
      hwrite_q    <= 1'b0;
      htrans_q    <= T_IDLE;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      mode_q      <= 2'b00;
      lfsr_q      <= SEED;
      idx_q       <= '0;
      dp_vld_q    <= 1'b0;
      dp_wr_q     <= 1'b0;
      dp_addr_q   <= '0;
      dp_exp_q    <= '0;
    end else begin
      // Pipeline the accepted address phase into its data phase and
      // score the data phase that completes now.
      if (bus.hready_resp) begin
        dp_vld_q <= addr_acc;
        if (addr_acc) begin
          dp_wr_q   <= hwrite_q;
          dp_addr_q <= haddr_q;
          dp_exp_q  <= cur_pat;
        end
        if (chk_err) begin
          err_cnt_q <= err_cnt_d;
          if (err_cnt_q == '0) first_err_q <= dp_addr_q;
        end
      end

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            mode_q      <= mode;
            lfsr_q      <= SEED;
            idx_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // First cycle in WRITE only launches word 0; later cycles advance
          // on each accepted address phase.
          if (htrans_q != T_NSEQ) begin
            hsel_q   <= 1'b1;
            htrans_q <= T_NSEQ;
            hwrite_q <= 1'b1;
            haddr_q  <= BASE_ADDR;
          end else if (bus.hready_resp) begin
            hwdata_q <= cur_pat;
            lfsr_q   <= lfsr_next(lfsr_q);
            if (last_word) begin
              hsel_q   <= 1'b0;
              htrans_q <= T_IDLE;
              state_q  <= S_TURN;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              haddr_q <= haddr_q + ADDR_W'(BYTES);
            end
          end
        end
        S_TURN: begin
          if (bus.hready_resp) begin
            lfsr_q   <= SEED;
            idx_q    <= '0;
            hsel_q   <= 1'b1;
            htrans_q <= T_NSEQ;
            hwrite_q <= 1'b0;
            haddr_q  <= BASE_ADDR;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          if (bus.hready_resp) begin
            lfsr_q <= lfsr_next(lfsr_q);
            if (last_word) begin
              hsel_q   <= 1'b0;
              htrans_q <= T_IDLE;
              state_q  <= S_RD_LAST;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              haddr_q <= haddr_q + ADDR_W'(BYTES);
            end
          end
        end
        S_RD_LAST: begin
          if (bus.hready_resp) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.hsel        = hsel_q;
  assign bus.hwrite      = hwrite_q;
  assign bus.htrans      = htrans_q;
  assign bus.hsize       = HSIZE;
  assign bus.hburst      = 3'b000;
  assign bus.haddr       = haddr_q;
  assign bus.hwdata      = hwdata_q;
  assign bus.hready      = bus.hready_resp;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_addr  = first_err_q;

endmodule
